// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_timing_pkg
// Purpose  : Default 640x480@60 timing constants, derived line/frame totals,
//            coordinate width and a small window-compare helper shared by the
//            VGA sync controller and its counters.
// Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int COORD_W = 10;

  // True when coordinate v lies in the closed interval [lo, hi].
  function automatic logic in_range(input logic [COORD_W-1:0] v,
                                    input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_mod_counter
// Purpose  : Enabled modulo-N up counter. Exposes the registered count, the
//            next-state count and a wrap flag that is high on the enabled
//            edge that returns the count to zero.
// Revision : 1.0  initial release
// ============================================================================
module vga_mod_counter
  import vga_timing_pkg::*;
#(
  parameter int MODULUS = H_TOTAL,
  parameter int WIDTH   = COORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: hold, increment, or wrap to zero after the last value.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign wrap_o       = en_i && (count_q == LAST);

endmodule : vga_mod_counter
`default_nettype wire

// File: rtl/vga_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_ctrl
// Purpose  : VGA timing generator. Divides clk by two into a pixel enable,
//            runs horizontal/vertical position counters and produces
//            registered syncs, blanking, frame pulse and blanked colour that
//            are all aligned with pixel_x/pixel_y.
// Options  : VGA_FRAME_LATCH_EN - when defined, the colour switches are only
//            captured at frame start (tear-free); otherwise they are
//            captured on every pixel enable.
// Revision : 1.0  initial release
// ============================================================================
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_DISP = DEF_H_DISP,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         rgbswitches,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start,
  output logic [2:0]         rgb
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_DISP + H_FP;
  localparam int HS_HI = H_DISP + H_FP + H_SYNC - 1;
  localparam int VS_LO = V_DISP + V_FP;
  localparam int VS_HI = V_DISP + V_FP + V_SYNC - 1;

  logic               tick_q;
  logic               h_wrap, v_wrap, frame_wrap;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic [2:0] colour_q, colour_d;
  logic [2:0] rgb_q, rgb_d;

  vga_mod_counter #(.MODULUS(H_TOT), .WIDTH(COORD_W)) u_hcnt (
    .clk          (clk),
    .reset        (reset),
    .en_i         (tick_q),
    .count_o      (x_q),
    .count_next_o (x_d),
    .wrap_o       (h_wrap)
  );

  vga_mod_counter #(.MODULUS(V_TOT), .WIDTH(COORD_W)) u_vcnt (
    .clk          (clk),
    .reset        (reset),
    .en_i         (h_wrap),
    .count_o      (y_q),
    .count_next_o (y_d),
    .wrap_o       (v_wrap)
  );

  // Both counters return to zero on this edge: the next cycle is (0,0).
  assign frame_wrap = v_wrap;

  // Decode outputs from next-count values so they register in step with the counters.
  always_comb begin
    colour_d = colour_q;
`ifdef VGA_FRAME_LATCH_EN
    if (frame_wrap) colour_d = rgbswitches;
`else
    if (tick_q) colour_d = rgbswitches;
`endif
    hsync_d       = ~in_range(x_d, HS_LO, HS_HI);
    vsync_d       = ~in_range(y_d, VS_LO, VS_HI);
    video_on_d    = (int'(x_d) < H_DISP) && (int'(y_d) < V_DISP);
    frame_start_d = frame_wrap;
    rgb_d         = video_on_d ? colour_d : 3'b000;
  end

  // Pixel enable divider and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q        <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      colour_q      <= 3'b000;
      rgb_q         <= 3'b000;
    end else begin
      tick_q        <= ~tick_q;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      colour_q      <= colour_d;
      rgb_q         <= rgb_d;
    end
  end

  assign p_tick      = tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;

endmodule : vga_sync_ctrl
`default_nettype wire
